alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Parametrised successor to the combinational operand-B mux. Selects and extends ALU operands A and B from register-file reads, optional forwarded results, shift amount and immediate (sign/zero/upper extension), then registers them as a one-entry valid/ready ID→EX pipeline stage with flush. It sits between decode/register-file read and the ALU, and keeps a saturating stall-cycle counter for debug.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- IMM_W, 16, immediate width (IMM_W < DATA_W)
- SHAMT_W, 5, shift-amount width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decode presents a valid operand set
- in_ready  out  1  stage can accept this cycle
- r1_dout  in  DATA_W  register-file read port 1
- r2_dout  in  DATA_W  register-file read port 2
- immed  in  IMM_W  raw immediate
- shamt  in  SHAMT_W  shift amount
- ext_mode  in  2  00 sign, 01 zero, 10 upper, 11 treated as sign
- alu_src_a  in  1  0 A=reg path, 1 A=zero-extended shamt
- alu_src_b  in  1  0 B=reg path, 1 B=extended immediate
- fwd_a_sel, fwd_b_sel  in  2 each  00 regfile, 01 ex_result, 10 mem_result, 11 regfile (only with ALU_OP_FWD_EN)
- ex_result, mem_result  in  DATA_W  forwarded values (only with ALU_OP_FWD_EN)
- flush  in  1  kill stage contents
- out_valid  out  1  registered operands valid
- out_ready  in  1  ALU/EX accepts this cycle
- alu_a, alu_b  out  DATA_W  registered operands
- ext_immed  out  DATA_W  registered extended immediate (for branch/store address use)
- stall_cnt  out  CNT_W  saturating stall-cycle count

## Operation
- Extension: sign = {(DATA_W-IMM_W){immed[IMM_W-1]}, immed}; zero = {0…, immed}; upper = {immed, (DATA_W-IMM_W){0}}.
- Reg path A = fwd_a_sel mux over r1_dout/ex_result/mem_result; B likewise over r2_dout. Forward selects are ignored when the corresponding alu_src selects shamt/immediate.
- A = alu_src_a ? {0…, shamt} : regpathA; B = alu_src_b ? ext : regpathB.
- in_ready = !out_valid | out_ready (combinational, no dependency on in_valid).
- Load: in_valid & in_ready → alu_a, alu_b, ext_immed captured, out_valid←1.
- Drain without load: out_valid & out_ready & !(in_valid & in_ready) → out_valid←0; data registers hold.
- Hold: out_valid & !out_ready → all output registers unchanged.
- Flush: out_valid←0 next cycle, overrides a simultaneous load; data registers may load but are don't-care. in_ready unaffected by flush.
- stall_cnt increments each cycle with out_valid & !out_ready & !flush; saturates at all-ones; never wraps.

## Timing
- Latency 1 cycle: inputs accepted in cycle N appear on alu_a/alu_b in N+1 with out_valid=1.
- Full throughput: one operand set per cycle while out_ready=1.
- Reset (async assert, sync-released use): out_valid=0, alu_a=0, alu_b=0, ext_immed=0, stall_cnt=0; in_ready=1 immediately after reset.
- Reset mid-transfer discards held operands; no output until a new load.
- flush and out_ready same cycle: flush wins, out_valid=0 next cycle, no stall count.

## Configuration
- ALU_OP_FWD_EN defined: fwd_a_sel, fwd_b_sel, ex_result, mem_result ports and forward muxes present.
- Not defined: those ports absent; reg path A = r1_dout, B = r2_dout; all other behaviour identical.

## Test plan
- Extension: immed=16'h8001, alu_src_b=1, ext_mode 00/01/10/11 → alu_b = FFFF8001 / 00008001 / 80010000 / FFFF8001 one cycle after load.
- Shamt/reg: alu_src_a=1, shamt=5'h1F, r1_dout=DEADBEEF → alu_a=0000001F; alu_src_a=0 → DEADBEEF.
- Backpressure: load A=1 then out_ready=0 for 3 cycles with new in_valid → in_ready=0, alu_a stays 1, stall_cnt=3; out_ready=1 → next operand appears following cycle.
- Flush: load with flush=1 same cycle → out_valid=0 next cycle; flush while holding stalled data → out_valid=0, in_ready=1.
- Forwarding (ALU_OP_FWD_EN): r2=1, ex_result=2, mem_result=3, fwd_b_sel 01/10/11 → alu_b=2/3/1; alu_src_b=1 with fwd_b_sel=01 → alu_b=ext imm.
- Saturation/reset: CNT_W=2, stall 6 cycles → stall_cnt=3; assert rst_n=0 asynchronously mid-hold → out_valid, stall_cnt, alu_a/b =0 without clock edge.

Source files
------------

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ALU operand select/extend with registered valid/ready ID->EX stage
//
// Optional feature macro: ALU_OP_FWD_EN
//   defined   : fwd_a_sel/fwd_b_sel/ex_result/mem_result ports and forward muxes present
//   undefined : register path A = r1_dout, B = r2_dout

module alu_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  r1_dout,
    input  logic [DATA_W-1:0]  r2_dout,
    input  logic [IMM_W-1:0]   immed,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         ext_mode,
    input  logic               alu_src_a,
    input  logic               alu_src_b,
`ifdef ALU_OP_FWD_EN
    input  logic [1:0]         fwd_a_sel,
    input  logic [1:0]         fwd_b_sel,
    input  logic [DATA_W-1:0]  ex_result,
    input  logic [DATA_W-1:0]  mem_result,
`endif
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [DATA_W-1:0]  ext_immed,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] ext_val;
    logic [DATA_W-1:0] reg_path_a;
    logic [DATA_W-1:0] reg_path_b;
    logic [DATA_W-1:0] next_a;
    logic [DATA_W-1:0] next_b;
    logic              load;
    logic              stalled;

    // Immediate extension; the reserved mode 11 falls back to sign extension
    always_comb begin
        ext_val = {{(DATA_W-IMM_W){immed[IMM_W-1]}}, immed};
        case (ext_mode)
            EXT_SIGN:  ext_val = {{(DATA_W-IMM_W){immed[IMM_W-1]}}, immed};
            EXT_ZERO:  ext_val = {{(DATA_W-IMM_W){1'b0}}, immed};
            EXT_UPPER: ext_val = {immed, {(DATA_W-IMM_W){1'b0}}};
            default:   ext_val = {{(DATA_W-IMM_W){immed[IMM_W-1]}}, immed};
        endcase
    end

`ifdef ALU_OP_FWD_EN
    // Register path selection with forwarding from EX and MEM; 11 reads the regfile
    always_comb begin
        reg_path_a = r1_dout;
        reg_path_b = r2_dout;
        case (fwd_a_sel)
            FWD_EX:  reg_path_a = ex_result;
            FWD_MEM: reg_path_a = mem_result;
            default: reg_path_a = r1_dout;
        endcase
        case (fwd_b_sel)
            FWD_EX:  reg_path_b = ex_result;
            FWD_MEM: reg_path_b = mem_result;
            default: reg_path_b = r2_dout;
        endcase
    end
`else
    // Register path comes straight from the register file
    always_comb begin
        reg_path_a = r1_dout;
        reg_path_b = r2_dout;
    end
`endif

    // Final operand muxes; forward selects are irrelevant when shamt/immediate is chosen
    always_comb begin
        next_a = alu_src_a ? {{(DATA_W-SHAMT_W){1'b0}}, shamt} : reg_path_a;
        next_b = alu_src_b ? ext_val : reg_path_b;
    end

    // Handshake: the single entry can be refilled in the same cycle it drains
    always_comb begin
        in_ready = !out_valid || out_ready;
        load     = in_valid && in_ready;
        stalled  = out_valid && !out_ready && !flush;
    end

    // Valid flag: flush kills the entry even if a load happens in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Operand registers: capture on load, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            ext_immed <= '0;
        end else if (load) begin
            alu_a     <= next_a;
            alu_b     <= next_b;
            ext_immed <= ext_val;
        end
    end

    // Debug stall counter: counts backpressured cycles, sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - randomized and directed bench for alu_operand_stage against a behavioural model

module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] r1_dout = '0;
    logic [31:0] r2_dout = '0;
    logic [15:0] immed = '0;
    logic [4:0]  shamt = '0;
    logic [1:0]  ext_mode = '0;
    logic        alu_src_a = 1'b0;
    logic        alu_src_b = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
`ifdef ALU_OP_FWD_EN
    logic [1:0]  fwd_a_sel = '0;
    logic [1:0]  fwd_b_sel = '0;
    logic [31:0] ex_result = '0;
    logic [31:0] mem_result = '0;
`endif

    logic        in_ready, out_valid;
    logic [31:0] alu_a, alu_b, ext_immed;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2;
    logic [31:0] alu_a2, alu_b2, ext_immed2;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.DATA_W(32), .IMM_W(16), .SHAMT_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .r1_dout(r1_dout), .r2_dout(r2_dout), .immed(immed), .shamt(shamt),
        .ext_mode(ext_mode), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
`ifdef ALU_OP_FWD_EN
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .ex_result(ex_result), .mem_result(mem_result),
`endif
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .ext_immed(ext_immed), .stall_cnt(stall_cnt)
    );

    alu_operand_stage #(.DATA_W(32), .IMM_W(16), .SHAMT_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .r1_dout(r1_dout), .r2_dout(r2_dout), .immed(immed), .shamt(shamt),
        .ext_mode(ext_mode), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
`ifdef ALU_OP_FWD_EN
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .ex_result(ex_result), .mem_result(mem_result),
`endif
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .alu_a(alu_a2), .alu_b(alu_b2), .ext_immed(ext_immed2), .stall_cnt(stall_cnt2)
    );

    // ---------------- behavioural model ----------------
    logic        m_valid = 1'b0;
    logic [31:0] m_a = '0, m_b = '0, m_e = '0;
    int          m_cnt = 0;
    int          m_cnt2 = 0;

    function automatic logic [31:0] f_ext(input logic [1:0] mode, input logic [15:0] imm);
        logic [31:0] r;
        if (mode == 2'd1)      r = 32'(imm);
        else if (mode == 2'd2) r = 32'(imm) << 16;
        else                   r = 32'($signed(imm));
        return r;
    endfunction

    function automatic logic [31:0] f_reg(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] ex, input logic [31:0] mem);
        if (sel == 2'd1) return ex;
        if (sel == 2'd2) return mem;
        return rf;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [1:0] sa, sb;
        logic [31:0] exv, memv;
        logic accept;
        if (!rst_n) begin
            m_valid = 1'b0; m_a = '0; m_b = '0; m_e = '0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            sa = 2'd0; sb = 2'd0; exv = '0; memv = '0;
`ifdef ALU_OP_FWD_EN
            sa = fwd_a_sel; sb = fwd_b_sel; exv = ex_result; memv = mem_result;
`endif
            accept = in_valid && (!m_valid || out_ready);
            if (m_valid && !out_ready && !flush) begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
            end
            if (accept) begin
                m_a = alu_src_a ? 32'(shamt) : f_reg(sa, r1_dout, exv, memv);
                m_b = alu_src_b ? f_ext(ext_mode, immed) : f_reg(sb, r2_dout, exv, memv);
                m_e = f_ext(ext_mode, immed);
            end
            if (flush)       m_valid = 1'b0;
            else if (accept) m_valid = 1'b1;
            else             m_valid = m_valid && !out_ready;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        chk("sat_out_valid", 32'(out_valid2), 32'(m_valid));
        chk("sat_stall_cnt", 32'(stall_cnt2), 32'(m_cnt2));
        if (m_valid) begin
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("ext_immed", ext_immed, m_e);
            chk("sat_alu_a", alu_a2, m_a);
            chk("sat_alu_b", alu_b2, m_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ext_exp [4];

    initial begin
        ext_exp[0] = 32'hFFFF8001; ext_exp[1] = 32'h00008001;
        ext_exp[2] = 32'h80010000; ext_exp[3] = 32'hFFFF8001;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_ext_immed", ext_immed, 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        step(); step();
        rst_n = 1'b1;
        step();

        // extension modes
        out_ready = 1'b1; in_valid = 1'b1; alu_src_b = 1'b1; immed = 16'h8001;
        for (int m = 0; m < 4; m++) begin
            ext_mode = 2'(m);
            step();
            chk("ext_alu_b", alu_b, ext_exp[m]);
            chk("ext_valid", 32'(out_valid), 32'h1);
        end

        // shift amount vs register path
        alu_src_a = 1'b1; shamt = 5'h1F; r1_dout = 32'hDEADBEEF;
        step();
        chk("shamt_alu_a", alu_a, 32'h0000001F);
        alu_src_a = 1'b0;
        step();
        chk("reg_alu_a", alu_a, 32'hDEADBEEF);

        // backpressure
        r1_dout = 32'd1;
        step();
        out_ready = 1'b0; r1_dout = 32'd2;
        #1 chk("bp_in_ready", 32'(in_ready), 32'h0);
        step(); step(); step();
        chk("bp_alu_a_hold", alu_a, 32'd1);
        chk("bp_stall_cnt", 32'(stall_cnt), 32'd3);
        out_ready = 1'b1;
        step();
        chk("bp_next_alu_a", alu_a, 32'd2);
        in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(out_valid), 32'h0);

        // flush with load, then flush of stalled data
        in_valid = 1'b1; flush = 1'b1;
        step();
        chk("flush_load_valid", 32'(out_valid), 32'h0);
        flush = 1'b0;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        chk("flush_hold_valid", 32'(out_valid), 32'h0);
        chk("flush_hold_in_ready", 32'(in_ready), 32'h1);
        chk("flush_stall_cnt", 32'(stall_cnt), 32'd4);
        flush = 1'b0;

`ifdef ALU_OP_FWD_EN
        out_ready = 1'b1; in_valid = 1'b1; alu_src_b = 1'b0;
        r2_dout = 32'd1; ex_result = 32'd2; mem_result = 32'd3;
        fwd_b_sel = 2'd1; step(); chk("fwd_ex", alu_b, 32'd2);
        fwd_b_sel = 2'd2; step(); chk("fwd_mem", alu_b, 32'd3);
        fwd_b_sel = 2'd3; step(); chk("fwd_rf", alu_b, 32'd1);
        fwd_b_sel = 2'd1; alu_src_b = 1'b1; ext_mode = 2'd0; immed = 16'h8001;
        step(); chk("fwd_ignored", alu_b, 32'hFFFF8001);
        fwd_b_sel = 2'd0; in_valid = 1'b0; out_ready = 1'b0;
        step();
`endif

        // saturation: six stalled cycles on a loaded entry
        out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("sat_cnt2", 32'(stall_cnt2), 32'd3);

        // asynchronous reset mid-hold
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_stall", 32'(stall_cnt), 32'h0);
        chk("arst_alu_a", alu_a, 32'h0);
        chk("arst_alu_b", alu_b, 32'h0);
        chk("arst_cnt2", 32'(stall_cnt2), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = $urandom_range(1) == 1;
            flush     = ($urandom_range(7) == 0);
            r1_dout   = $urandom;
            r2_dout   = $urandom;
            immed     = 16'($urandom);
            shamt     = 5'($urandom);
            ext_mode  = 2'($urandom);
            alu_src_a = 1'($urandom);
            alu_src_b = 1'($urandom);
`ifdef ALU_OP_FWD_EN
            fwd_a_sel  = 2'($urandom);
            fwd_b_sel  = 2'($urandom);
            ex_result  = $urandom;
            mem_result = $urandom;
`endif
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
